// File: rtl/timer_pkg.sv
// Shared types and defaults for the countdown timer slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package timer_pkg;

    localparam int DEF_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle between a timer client and countdown_timer.
// Latency: n/a (wires only).
// Backpressure: none; commands are single-cycle strobes or levels.
interface countdown_timer_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             pause;
    logic             stop;
    logic             auto_reload;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             expired;
    logic             done;

    // Client side: issues commands, observes status.
    modport master (
        output load_val, start, pause, stop, auto_reload,
        input  count, busy, expired, done
    );

    // Timer side: consumes commands, drives status.
    modport slave (
        input  load_val, start, pause, stop, auto_reload,
        output count, busy, expired, done
    );
endinterface

// File: rtl/tick_sync.sv
// Synchronises an asynchronous tick and emits a one-cycle pulse per rising edge.
// Latency: SYNC_STAGES+1 clk edges from async_in rise to pulse consumption.
// Backpressure: none; pulses are not queued, falling edges are ignored.
module tick_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic arst,
    input  logic async_in,
    output logic pulse_out
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Synchroniser chain followed by the edge-detect history flop; both clear with arst.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign pulse_out = sync_q[SYNC_STAGES-1] & ~prev_q;
endmodule

// File: rtl/countdown_timer.sv
// Programmable down-counter on a synchronised divided-clock timebase, one-shot or periodic.
// Latency: commands act on the next clk edge; expired is registered one cycle after the final tick.
// Backpressure: none; ticks arriving in PAUSE are dropped, stop beats start beats pause beats tick.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             tick_in,
    countdown_timer_if.slave ctl
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             mode_q, mode_d;
    logic             expired_q, expired_d;
    logic             busy_q, done_q;
    logic             tick_evt;

    tick_sync #(.SYNC_STAGES(SYNC_STAGES)) u_tick_sync (
        .clk      (clk),
        .arst     (arst),
        .async_in (tick_in),
        .pulse_out(tick_evt)
    );

    // Next-state, counter and expiry decision in priority order stop > start > pause > tick.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        reload_d  = reload_q;
        mode_d    = mode_q;
        expired_d = 1'b0;
        if (ctl.stop) begin
            state_d = ST_IDLE;
            count_d = '0;
        end else if (ctl.start) begin
            if (ctl.load_val != '0) begin
                count_d  = ctl.load_val;
                reload_d = ctl.load_val;
                mode_d   = ctl.auto_reload;
                state_d  = ST_RUN;
            end else begin
                // Zero terminal count expires straight away without needing a tick.
                count_d   = '0;
                expired_d = 1'b1;
                state_d   = ST_DONE;
            end
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (ctl.pause) begin
                        state_d = ST_PAUSE;
                    end else if (tick_evt) begin
                        if (count_q > ONE) begin
                            count_d = count_q - ONE;
                        end else if (count_q == ONE) begin
                            expired_d = 1'b1;
                            if (mode_q) begin
                                count_d = reload_q;
                            end else begin
                                count_d = '0;
                                state_d = ST_DONE;
                            end
                        end
                    end
                end
                ST_PAUSE: begin
                    if (!ctl.pause) begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                    count_d = '0;
                end
                default: begin
                end
            endcase
        end
    end

    // State, counter and registered status outputs.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            reload_q  <= '0;
            mode_q    <= 1'b0;
            expired_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            mode_q    <= mode_d;
            expired_q <= expired_d;
            busy_q    <= (state_d == ST_RUN) || (state_d == ST_PAUSE);
            done_q    <= (state_d == ST_DONE);
        end
    end

    assign ctl.count   = count_q;
    assign ctl.busy    = busy_q;
    assign ctl.expired = expired_q;
    assign ctl.done    = done_q;
endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer.
// Latency: ticks are held long enough to pass the synchroniser before checks.
// Backpressure: n/a.
module tb_countdown_timer;
    localparam int W = 16;

    logic clk = 1'b0;
    logic arst;
    logic tick_in;

    int tests_run    = 0;
    int tests_failed = 0;
    int exp_total    = 0;
    int exp_base;

    countdown_timer_if #(.WIDTH(W)) ctl ();

    countdown_timer #(.WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk    (clk),
        .arst   (arst),
        .tick_in(tick_in),
        .ctl    (ctl.slave)
    );

    always #5 clk = ~clk;

    // Count every cycle that expired is high, sampled away from the active edge.
    always @(negedge clk) begin
        if (ctl.expired) exp_total++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start(input logic [W-1:0] val, input logic ar);
        @(negedge clk);
        ctl.load_val    = val;
        ctl.auto_reload = ar;
        ctl.start       = 1'b1;
        @(negedge clk);
        ctl.start       = 1'b0;
    endtask

    task automatic do_stop();
        @(negedge clk);
        ctl.stop = 1'b1;
        @(negedge clk);
        ctl.stop = 1'b0;
    endtask

    task automatic tick_edge();
        @(negedge clk);
        tick_in = 1'b1;
        wait_cyc(6);
        tick_in = 1'b0;
        wait_cyc(6);
    endtask

    initial begin
        arst            = 1'b0;
        tick_in         = 1'b0;
        ctl.load_val    = '0;
        ctl.start       = 1'b0;
        ctl.pause       = 1'b0;
        ctl.stop        = 1'b0;
        ctl.auto_reload = 1'b0;
        wait_cyc(3);
        check("rst_count",   32'(ctl.count),   32'd0);
        check("rst_busy",    32'(ctl.busy),    32'd0);
        check("rst_done",    32'(ctl.done),    32'd0);
        check("rst_expired", 32'(ctl.expired), 32'd0);
        arst = 1'b1;
        wait_cyc(2);

        // One-shot 3 -> 2 -> 1 -> 0, then a stray edge.
        exp_base = exp_total;
        do_start(16'd3, 1'b0);
        check("os_load",  32'(ctl.count), 32'd3);
        check("os_busy0", 32'(ctl.busy),  32'd1);
        tick_edge();
        check("os_c2", 32'(ctl.count), 32'd2);
        tick_edge();
        check("os_c1", 32'(ctl.count), 32'd1);
        tick_edge();
        check("os_c0",   32'(ctl.count), 32'd0);
        check("os_exp",  32'(exp_total - exp_base), 32'd1);
        check("os_done", 32'(ctl.done),  32'd1);
        check("os_busy", 32'(ctl.busy),  32'd0);
        tick_edge();
        check("os_c0_hold", 32'(ctl.count), 32'd0);
        check("os_exp_once", 32'(exp_total - exp_base), 32'd1);

        // Auto-reload period 2 over 6 edges.
        exp_base = exp_total;
        do_start(16'd2, 1'b1);
        check("ar_load", 32'(ctl.count), 32'd2);
        for (int i = 1; i <= 6; i++) begin
            tick_edge();
            check($sformatf("ar_count_%0d", i), 32'(ctl.count), (i % 2 == 1) ? 32'd1 : 32'd2);
            check($sformatf("ar_exp_%0d", i), 32'(exp_total - exp_base), 32'(i / 2));
            check($sformatf("ar_busy_%0d", i), 32'(ctl.busy), 32'd1);
        end

        // Pause: restart from RUN with 5, two edges, hold across three, resume.
        exp_base = exp_total;
        do_start(16'd5, 1'b0);
        check("pa_load", 32'(ctl.count), 32'd5);
        tick_edge();
        tick_edge();
        check("pa_c3", 32'(ctl.count), 32'd3);
        @(negedge clk);
        ctl.pause = 1'b1;
        wait_cyc(2);
        check("pa_busy", 32'(ctl.busy), 32'd1);
        for (int i = 0; i < 3; i++) tick_edge();
        check("pa_hold", 32'(ctl.count), 32'd3);
        @(negedge clk);
        ctl.pause = 1'b0;
        wait_cyc(2);
        tick_edge();
        check("pa_c2", 32'(ctl.count), 32'd2);
        tick_edge();
        check("pa_c1", 32'(ctl.count), 32'd1);
        check("pa_noexp", 32'(exp_total - exp_base), 32'd0);
        tick_edge();
        check("pa_c0",   32'(ctl.count), 32'd0);
        check("pa_exp",  32'(exp_total - exp_base), 32'd1);
        check("pa_done", 32'(ctl.done), 32'd1);

        // Start and stop together during RUN: stop wins.
        exp_base = exp_total;
        do_start(16'd7, 1'b0);
        tick_edge();
        check("pr_c6", 32'(ctl.count), 32'd6);
        @(negedge clk);
        ctl.load_val = 16'd9;
        ctl.start    = 1'b1;
        ctl.stop     = 1'b1;
        @(negedge clk);
        ctl.start    = 1'b0;
        ctl.stop     = 1'b0;
        wait_cyc(2);
        check("pr_count", 32'(ctl.count), 32'd0);
        check("pr_busy",  32'(ctl.busy),  32'd0);
        check("pr_done",  32'(ctl.done),  32'd0);
        check("pr_exp",   32'(exp_total - exp_base), 32'd0);

        // Stop lands in the same cycle as the tick that would expire count 1.
        exp_base = exp_total;
        do_start(16'd1, 1'b0);
        @(negedge clk);
        tick_in = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        ctl.stop = 1'b1;
        @(negedge clk);
        ctl.stop = 1'b0;
        wait_cyc(4);
        tick_in = 1'b0;
        wait_cyc(4);
        check("ps_exp",   32'(exp_total - exp_base), 32'd0);
        check("ps_count", 32'(ctl.count), 32'd0);
        check("ps_busy",  32'(ctl.busy),  32'd0);
        check("ps_done",  32'(ctl.done),  32'd0);

        // Zero load expires without any tick, then stop clears DONE.
        exp_base = exp_total;
        do_start(16'd0, 1'b1);
        wait_cyc(2);
        check("z_exp",   32'(exp_total - exp_base), 32'd1);
        check("z_done",  32'(ctl.done),  32'd1);
        check("z_count", 32'(ctl.count), 32'd0);
        check("z_busy",  32'(ctl.busy),  32'd0);
        do_stop();
        wait_cyc(1);
        check("z_stop_done", 32'(ctl.done), 32'd0);

        // Asynchronous reset in the middle of RUN.
        do_start(16'd7, 1'b0);
        check("mr_c7", 32'(ctl.count), 32'd7);
        @(negedge clk);
        #1 arst = 1'b0;
        #1;
        check("mr_count",   32'(ctl.count),   32'd0);
        check("mr_busy",    32'(ctl.busy),    32'd0);
        check("mr_done",    32'(ctl.done),    32'd0);
        check("mr_expired", 32'(ctl.expired), 32'd0);
        wait_cyc(2);
        arst = 1'b1;
        wait_cyc(2);
        tick_edge();
        check("mr_idle_count", 32'(ctl.count), 32'd0);
        check("mr_idle_busy",  32'(ctl.busy),  32'd0);
        check("mr_idle_done",  32'(ctl.done),  32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Programmable down-counting timer. It consumes the divided clock produced by the ripple clock divider stage (the divide-by-16 output) as its timebase.
- The divider output is generated from ripple flops, so this block treats it as asynchronous to clk. It synchronises the signal, detects its rising edges, and counts them down from a loaded value.
- It raises an expiry pulse and offers one-shot or auto-reload operation for downstream timer/display logic.

Parameters:
- WIDTH, 16, bit width of load value and counter
- SYNC_STAGES, 2, number of synchroniser flops on tick_in (minimum 2)

Ports:
- clk  input  1  system clock; every flop in this block is clocked by clk
- arst  input  1  asynchronous reset, active-low
- tick_in  input  1  divided clock from the divider stage; asynchronous to clk
- load_val  input  WIDTH  terminal count, captured on start
- start  input  1  single-cycle request to load and run
- pause  input  1  level; while high in RUN the counter holds
- stop  input  1  single-cycle abort back to IDLE
- auto_reload  input  1  captured on start; 1 = periodic, 0 = one-shot
- count  output  WIDTH  current remaining tick count
- busy  output  1  high in RUN or PAUSE
- expired  output  1  single-cycle pulse when the count reaches 0
- done  output  1  level; high in DONE state

Behaviour:
- Reset (arst low, asynchronous):
  - Outputs: count=0, busy=0, expired=0, done=0.
  - Internal state: state=IDLE, the synchroniser chain, the edge-detect flop, and the reload and mode registers all clear to 0.
- Tick path:
  - tick_in passes through SYNC_STAGES flops, then one edge-detect flop.
  - tick_evt = sync_out & ~prev. It is a 1-cycle pulse per rising edge of tick_in.
  - Latency from a tick_in rising edge to tick_evt is SYNC_STAGES+1 clk edges, ±1 cycle of sampling uncertainty.
  - Falling edges are ignored.
- States: IDLE, RUN, PAUSE, DONE.
- Event priority within a cycle: stop > start > pause > tick_evt.
- IDLE:
  - start with load_val!=0: count<=load_val, reload_reg<=load_val, mode<=auto_reload, go to RUN.
  - start with load_val==0: expired pulses next cycle, go to DONE (auto_reload is ignored).
- RUN:
  - tick_evt with count>1: count decrements by 1.
  - tick_evt with count==1, one-shot: count<=0, expired<=1 (registered, so visible the cycle after tick_evt), go to DONE.
  - tick_evt with count==1, auto-reload: count<=reload_reg, expired<=1, stay in RUN.
  - pause high: go to PAUSE. No decrement occurs that cycle, even if tick_evt is present.
- PAUSE:
  - count holds and tick_evt is discarded (it is not queued).
  - pause low: return to RUN the next cycle.
- DONE:
  - done=1 and count=0.
  - start restarts exactly as from IDLE.
  - stop goes to IDLE.
- stop in any state: go to IDLE and count<=0. No expired pulse is generated, even if the count would have reached 0 that cycle.
- start while in RUN or PAUSE: restart. Reload from load_val, recapture mode, go to RUN. This is legal and takes effect the next cycle.
- Output timing:
  - busy and done are registered and decode the state.
  - expired is high for exactly 1 cycle per expiry event.
- Arithmetic: unsigned. The counter never decrements below 0 and never wraps.
- Mid-operation reset: the asynchronous clear is immediate, and the first clk edge after arst deasserts leaves the block in IDLE.
- The synchroniser must not be bypassed or reset-skipped. It clears with arst.

Decomposition:
- Shared package (timer_pkg):
  - State enum (IDLE, RUN, PAUSE, DONE) in 2 bits.
  - Default WIDTH constant.
- Sub-module tick_sync:
  - Contains the SYNC_STAGES flop chain plus the edge-detect flop.
  - Ports: clk, arst, async_in, pulse_out.
  - It is instantiated once. The FSM and counter live in countdown_timer.

Test Plan:
- Reset: assert arst low mid-RUN with count=7 -> count=0, busy=0, done=0, expired=0 immediately; the state is IDLE after release.
- One-shot: load_val=3, auto_reload=0, start, then 3 tick_in rising edges -> count goes 3→2→1→0, exactly one expired pulse, done=1, busy=0; a 4th edge leaves count at 0.
- Auto-reload: load_val=2, auto_reload=1, 6 edges -> expired pulses after edges 2, 4 and 6; count sequence is 2,1,2,1,2,1,2; busy stays 1.
- Pause: load_val=5, 2 edges (count=3), pause high across 3 edges, release, 3 edges -> count holds at 3 during the pause, then expires after the final edge.
- Priority: start and stop in the same cycle during RUN -> IDLE with count=0 and no expired pulse. A stop coinciding with the tick_evt that would expire the count -> no expired pulse.
- Zero load: load_val=0 with start -> one expired pulse, done=1, count=0, with no tick required.
